// File: rtl/mult_pkg.sv
// Shared definitions for the D1 unsigned shift-add multiplier:
// default operand width, derived register/count widths and the sequencer command bundle.
package mult_pkg;

  localparam int N_DEFAULT = 4;

  // Accumulator register width: carry, upper half A and lower half Q.
  function automatic int reg_w(input int n);
    return 2 * n + 1;
  endfunction

  // Iteration counter width; it must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef struct packed {
    logic load;
    logic add;
    logic shift;
    logic decrement;
  } cmd_t;

endpackage

// File: rtl/mult_down_counter.sv
// Loadable down-counter that saturates at zero and raises a sticky underflow
// flag when asked to decrement past zero.
module mult_down_counter #(
  parameter int W    = 3,
  parameter int INIT = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         underflow
);

  always_ff @(posedge clk) begin
    if (!RESET) begin
      count     <= '0;
      underflow <= 1'b0;
    end else if (load) begin
      count     <= W'(INIT);
      underflow <= 1'b0;
    end else if (dec) begin
      if (count == '0) begin
        underflow <= 1'b1;
      end else begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add datapath for the D1 multiplier: executes one-hot sequencer commands on the
// {C, A, Q} accumulator register and the iteration counter.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 LOAD,
  input  logic                 ADD,
  input  logic                 SHIFT,
  input  logic                 DECREMENT,
  input  logic [N-1:0]         multiplicand,
  input  logic [N-1:0]         multiplier,
  output logic [reg_w(N)-1:0]  register,
  output logic [cnt_w(N)-1:0]  count,
  output logic [2*N-1:0]       product,
  output logic                 underflow
);

  localparam int RW = reg_w(N);
  localparam int CW = cnt_w(N);

  // Commands are level-sensitive for one clock: whatever is high at the rising edge
  // is executed, with LOAD overriding the others and ADD/SHIFT/DECREMENT combinable.
  cmd_t cmd;
  assign cmd = '{load: LOAD, add: ADD, shift: SHIFT, decrement: DECREMENT};

  logic [N-1:0] m_reg;
  logic [N-1:0] a_half;
  logic [N-1:0] q_half;
  logic [N:0]   sum;
  logic [RW-1:0] added;

  assign a_half = register[2*N-1:N];
  assign q_half = register[N-1:0];
  assign sum    = {1'b0, a_half} + {1'b0, m_reg};
  assign added  = {sum, q_half};

  always_ff @(posedge clk) begin
    if (!RESET) begin
      register <= '0;
      m_reg    <= '0;
    end else if (cmd.load) begin
      m_reg    <= multiplicand;
      register <= {1'b0, {N{1'b0}}, multiplier};
    end else begin
      case ({cmd.add, cmd.shift})
        2'b10:   register <= added;
        2'b01:   register <= {1'b0, register[RW-1:1]};
        // Fused step: the shift sees the post-add value, carry included.
        2'b11:   register <= {1'b0, added[RW-1:1]};
        default: register <= register;
      endcase
    end
  end

  mult_down_counter #(
    .W    (CW),
    .INIT (N)
  ) u_counter (
    .clk       (clk),
    .RESET     (RESET),
    .load      (cmd.load),
    .dec       (cmd.decrement),
    .count     (count),
    .underflow (underflow)
  );

  assign product = register[2*N-1:0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: reset, full multiplications, fused step,
// counter saturation/underflow and mid-operation LOAD/RESET.
module tb_multiplier_datapath;

  logic       clk = 1'b0;
  logic       RESET;
  logic       LOAD, ADD, SHIFT, DECREMENT;
  logic [3:0] multiplicand, multiplier;
  logic [8:0] register;
  logic [2:0] count;
  logic [7:0] product;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multiplier_datapath #(.N(4)) dut (
    .clk          (clk),
    .RESET        (RESET),
    .LOAD         (LOAD),
    .ADD          (ADD),
    .SHIFT        (SHIFT),
    .DECREMENT    (DECREMENT),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .register     (register),
    .count        (count),
    .product      (product),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one command set for one rising edge, then settle just past the edge.
  task automatic step(input logic r, input logic l, input logic a, input logic s, input logic d);
    RESET = r; LOAD = l; ADD = a; SHIFT = s; DECREMENT = d;
    @(posedge clk);
    #1;
    LOAD = 1'b0; ADD = 1'b0; SHIFT = 1'b0; DECREMENT = 1'b0; RESET = 1'b1;
  endtask

  task automatic load_ops(input logic [3:0] m, input logic [3:0] q);
    multiplicand = m;
    multiplier   = q;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // One fused iteration: optional add, shift and decrement in a single cycle.
  task automatic iter(input logic add_en);
    step(1'b1, 1'b0, add_en, 1'b1, 1'b1);
  endtask

  initial begin
    RESET = 1'b0; LOAD = 1'b0; ADD = 1'b0; SHIFT = 1'b0; DECREMENT = 1'b0;
    multiplicand = 4'd9; multiplier = 4'd6;
    #2;

    // 1. reset dominates toggling commands
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst1_reg", register, 9'h000);
    chk("rst1_cnt", count, 3'd0);
    chk("rst1_uf",  underflow, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst2_reg", register, 9'h000);
    chk("rst2_cnt", count, 3'd0);
    chk("rst2_uf",  underflow, 1'b0);

    // 2. 13 * 11 = 143 using fused iterations, Q bits LSB first 1,1,0,1
    load_ops(4'd13, 4'd11);
    chk("m13_load_reg", register, 9'h00B);
    chk("m13_load_cnt", count, 3'd4);
    iter(1'b1);
    chk("m13_it1_reg", register, 9'h06D);
    chk("m13_it1_cnt", count, 3'd3);
    iter(1'b1);
    iter(1'b0);
    iter(1'b1);
    chk("m13_reg",  register, 9'h08F);
    chk("m13_prod", product, 8'd143);
    chk("m13_cnt",  count, 3'd0);

    // 3. 15 * 15 with separate ADD and SHIFT+DECREMENT cycles
    load_ops(4'd15, 4'd15);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("m15_add1", register, 9'h0FF);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("m15_sh1", register, 9'h07F);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("m15_add2_carry", register, 9'h16F);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("m15_sh2", register, 9'h0B7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("m15_sh3", register, 9'h0D3);
    chk("m15_c3", register[8], 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("m15_prod", product, 8'hE1);
    chk("m15_c4",   register[8], 1'b0);
    chk("m15_cnt",  count, 3'd0);

    // 5. decrement at zero saturates and sets sticky underflow
    chk("uf_before", underflow, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("uf_cnt", count, 3'd0);
    chk("uf_set", underflow, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("uf_hold", underflow, 1'b1);
    chk("idle_hold_reg", register, 9'h0E1);

    // 4. zero multiplier via shifts only, then a fused add+shift
    load_ops(4'd7, 4'd0);
    chk("uf_clr", underflow, 1'b0);
    chk("m7_load_cnt", count, 3'd4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("m7_prod", product, 8'd0);
    chk("m7_cnt_nodec", count, 3'd4);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("fused_hi", register[8:4], 5'b00011);
    chk("fused_b3", register[3], 1'b1);
    chk("fused_reg", register, 9'h038);

    // 6. LOAD mid-operation aborts and restarts
    load_ops(4'd9, 4'd6);
    iter(1'b0);
    iter(1'b1);
    chk("mid_reg", register, 9'h049);
    chk("mid_cnt", count, 3'd2);
    multiplicand = 4'd3; multiplier = 4'd5;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reload_reg", register, 9'h005);
    chk("reload_cnt", count, 3'd4);
    iter(1'b1);
    iter(1'b0);
    iter(1'b1);
    iter(1'b0);
    chk("m3_prod", product, 8'd15);
    chk("m3_reg",  register, 9'h00F);
    chk("m3_cnt",  count, 3'd0);

    // 6b. RESET mid-operation clears everything including M
    load_ops(4'd9, 4'd6);
    iter(1'b0);
    iter(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_uf", underflow, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("mrst_reg", register, 9'h000);
    chk("mrst_cnt", count, 3'd0);
    chk("mrst_uf",  underflow, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mrst_m_cleared", register, 9'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
